// File: rtl/scrambler_ctrl_if.sv
// Symbol stream bundle between the TX mux, the scrambler controller and the 8b/10b encoder.
// The master side feeds symbols in and drains them; the slave side is the controller.
interface scrambler_ctrl_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_k;
  logic       in_ts_start;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_k;

  modport master (
    output in_valid, in_data, in_k, in_ts_start, out_ready,
    input  in_ready, out_valid, out_data, out_k
  );

  modport slave (
    input  in_valid, in_data, in_k, in_ts_start, out_ready,
    output in_ready, out_valid, out_data, out_k
  );
endinterface

// File: rtl/scrambler_ctrl.sv
// Gen1/Gen2 TX scrambler sequencing: decides per accepted symbol whether the external LFSR
// is re-seeded, advanced or held, and whether the symbol is XORed with the keystream.
module scrambler_ctrl #(
  parameter logic [7:0]  COM_CODE = 8'hBC,
  parameter logic [7:0]  SKP_CODE = 8'h1C,
  parameter int unsigned TS_LEN   = 16
) (
  input  logic       pclk,
  input  logic       reset,
  scrambler_ctrl_if.slave bus,
  input  logic       scr_disable,
  input  logic [7:0] lfsr_key,
  output logic       lfsr_reset,
  output logic       lfsr_advance,
  output logic       ts_active
);
  localparam int unsigned      CNT_W    = $clog2(TS_LEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TS_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [0:0] {
    ST_DATA = 1'b0,
    ST_TS   = 1'b1
  } state_t;

  state_t           state_r;
  logic [CNT_W-1:0] ts_cnt_r;
  logic             out_valid_r;
  logic [7:0]       out_data_r;
  logic             out_k_r;

  logic             accept_s;
  logic             is_com_s;
  logic             is_skp_s;
  logic             scramble_s;
  logic [7:0]       data_nxt_s;

  assign bus.in_ready  = ~out_valid_r | bus.out_ready;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign bus.out_k     = out_k_r;

  // Symbol classification and LFSR pulses; pulses must be same-cycle so the key stays aligned back-to-back
  always_comb begin
    accept_s     = bus.in_valid & bus.in_ready & ~reset;
    is_com_s     = bus.in_k & (bus.in_data == COM_CODE);
    is_skp_s     = bus.in_k & (bus.in_data == SKP_CODE);
    scramble_s   = ~bus.in_k & (state_r == ST_DATA) & ~scr_disable;
    if (scramble_s) begin
      data_nxt_s = bus.in_data ^ lfsr_key;
    end else begin
      data_nxt_s = bus.in_data;
    end
    lfsr_reset   = accept_s & is_com_s;
    lfsr_advance = accept_s & ~is_com_s & ~is_skp_s;
  end

  // Output register, TS ordered-set tracking and state machine
  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      out_valid_r <= 1'b0;
      out_data_r  <= 8'h00;
      out_k_r     <= 1'b0;
      ts_active   <= 1'b0;
      ts_cnt_r    <= '0;
      state_r     <= ST_DATA;
    end else begin
      if (accept_s) begin
        out_valid_r <= 1'b1;
        out_data_r  <= data_nxt_s;
        out_k_r     <= bus.in_k;
      end else if (bus.out_ready) begin
        out_valid_r <= 1'b0;
      end

      if (accept_s) begin
        if (is_com_s) begin
          // A COM always starts over, aborting any set already in progress
          if (bus.in_ts_start) begin
            state_r   <= ST_TS;
            ts_cnt_r  <= CNT_ONE;
            ts_active <= 1'b1;
          end else begin
            state_r   <= ST_DATA;
            ts_cnt_r  <= '0;
            ts_active <= 1'b0;
          end
        end else begin
          case (state_r)
            ST_TS: begin
              if (ts_cnt_r == CNT_LAST) begin
                state_r   <= ST_DATA;
                ts_cnt_r  <= '0;
                ts_active <= 1'b0;
              end else begin
                ts_cnt_r  <= ts_cnt_r + CNT_ONE;
              end
            end
            ST_DATA: begin
              ts_cnt_r  <= '0;
              ts_active <= 1'b0;
            end
            default: begin
              state_r   <= ST_DATA;
              ts_cnt_r  <= '0;
              ts_active <= 1'b0;
            end
          endcase
        end
      end
    end
  end
endmodule

// File: tb/tb_scrambler_ctrl.sv
// Directed bench for scrambler_ctrl with a behavioural Gen1/Gen2 LFSR (x^16+x^5+x^4+x^3+1)
// standing in for the external LFSR instance.
module tb_scrambler_ctrl;
  logic       pclk;
  logic       reset;
  logic       scr_disable;
  logic [7:0] lfsr_key;
  logic       lfsr_reset;
  logic       lfsr_advance;
  logic       ts_active;
  logic [15:0] lfsr_state;

  int checks   = 0;
  int failures = 0;
  int adv_cnt  = 0;
  int rst_cnt  = 0;
  int both_cnt = 0;
  int adv_snap;
  int rst_snap;

  scrambler_ctrl_if bus();

  scrambler_ctrl dut (
    .pclk        (pclk),
    .reset       (reset),
    .bus         (bus),
    .scr_disable (scr_disable),
    .lfsr_key    (lfsr_key),
    .lfsr_reset  (lfsr_reset),
    .lfsr_advance(lfsr_advance),
    .ts_active   (ts_active)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  function automatic logic [15:0] lfsr_step1(input logic [15:0] s);
    if (s[15]) return {s[14:0], 1'b0} ^ 16'h0039;
    else       return {s[14:0], 1'b0};
  endfunction

  function automatic logic [15:0] lfsr_step8(input logic [15:0] s);
    logic [15:0] v;
    v = s;
    for (int i = 0; i < 8; i++) v = lfsr_step1(v);
    return v;
  endfunction

  function automatic logic [7:0] lfsr_byte(input logic [15:0] s);
    logic [15:0] v;
    logic [7:0]  b;
    v = s;
    for (int i = 0; i < 8; i++) begin
      b[i] = v[15];
      v    = lfsr_step1(v);
    end
    return b;
  endfunction

  function automatic logic [7:0] key_after(input int n);
    logic [15:0] v;
    v = 16'hFFFF;
    for (int i = 0; i < n; i++) v = lfsr_step8(v);
    return lfsr_byte(v);
  endfunction

  // External LFSR instance model
  always @(posedge pclk or posedge reset) begin
    if (reset)             lfsr_state <= 16'hFFFF;
    else if (lfsr_reset)   lfsr_state <= 16'hFFFF;
    else if (lfsr_advance) lfsr_state <= lfsr_step8(lfsr_state);
  end
  assign lfsr_key = lfsr_byte(lfsr_state);

  // Pulse counters
  always @(posedge pclk) begin
    if (lfsr_advance)              adv_cnt  <= adv_cnt + 1;
    if (lfsr_reset)                rst_cnt  <= rst_cnt + 1;
    if (lfsr_reset & lfsr_advance) both_cnt <= both_cnt + 1;
  end

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic snap();
    adv_snap = adv_cnt;
    rst_snap = rst_cnt;
  endtask

  // Present one symbol and wait (bounded) until it is accepted
  task automatic send(input logic [7:0] d, input logic k, input logic ts);
    bit done;
    done            = 1'b0;
    bus.in_valid    = 1'b1;
    bus.in_data     = d;
    bus.in_k        = k;
    bus.in_ts_start = ts;
    #1;
    for (int i = 0; i < 50 && !done; i++) begin
      if (bus.in_ready) done = 1'b1;
      step();
    end
    if (!done) check_value("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle();
    bus.in_valid    = 1'b0;
    bus.in_ts_start = 1'b0;
  endtask

  initial begin
    reset           = 1'b1;
    scr_disable     = 1'b0;
    bus.in_valid    = 1'b0;
    bus.in_data     = 8'h00;
    bus.in_k        = 1'b0;
    bus.in_ts_start = 1'b0;
    bus.out_ready   = 1'b1;
    step();
    step();
    check_value("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check_value("rst_out_data", {24'd0, bus.out_data}, 32'd0);
    check_value("rst_out_k", {31'd0, bus.out_k}, 32'd0);
    check_value("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check_value("rst_ts_active", {31'd0, ts_active}, 32'd0);
    check_value("rst_pulses", {30'd0, lfsr_reset, lfsr_advance}, 32'd0);
    reset = 1'b0;
    step();

    // COM then three scrambled zeros
    snap();
    send(8'hBC, 1'b1, 1'b0);
    check_value("t1_com_data", {24'd0, bus.out_data}, 32'hBC);
    check_value("t1_com_k", {31'd0, bus.out_k}, 32'd1);
    send(8'h00, 1'b0, 1'b0);
    check_value("t1_d0", {24'd0, bus.out_data}, 32'hFF);
    check_value("t1_d0_k", {31'd0, bus.out_k}, 32'd0);
    send(8'h00, 1'b0, 1'b0);
    check_value("t1_d1", {24'd0, bus.out_data}, 32'h17);
    send(8'h00, 1'b0, 1'b0);
    check_value("t1_d2", {24'd0, bus.out_data}, 32'hC0);
    check_value("t1_adv", adv_cnt - adv_snap, 32'd3);
    check_value("t1_rst", rst_cnt - rst_snap, 32'd1);

    // SKPs hold the LFSR
    snap();
    send(8'hBC, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      send(8'h1C, 1'b1, 1'b0);
      check_value("t2_skp", {24'd0, bus.out_data}, 32'h1C);
    end
    check_value("t2_adv_skp", adv_cnt - adv_snap, 32'd0);
    send(8'h00, 1'b0, 1'b0);
    check_value("t2_d", {24'd0, bus.out_data}, 32'hFF);
    check_value("t2_adv", adv_cnt - adv_snap, 32'd1);

    // TS ordered set: raw data, LFSR keeps advancing
    snap();
    send(8'hBC, 1'b1, 1'b1);
    check_value("t3_ts_active_com", {31'd0, ts_active}, 32'd1);
    for (int i = 1; i < 16; i++) begin
      send(8'h4A, 1'b0, 1'b0);
      check_value("t3_raw", {24'd0, bus.out_data}, 32'h4A);
      if (i == 14) check_value("t3_ts_active_14", {31'd0, ts_active}, 32'd1);
      if (i == 15) check_value("t3_ts_active_end", {31'd0, ts_active}, 32'd0);
    end
    check_value("t3_adv", adv_cnt - adv_snap, 32'd15);
    send(8'h00, 1'b0, 1'b0);
    check_value("t3_after_set", {24'd0, bus.out_data}, {24'd0, key_after(15)});

    // Backpressure: nothing moves while out_ready is low
    send(8'hBC, 1'b1, 1'b0);
    send(8'h00, 1'b0, 1'b0);
    check_value("t4_d0", {24'd0, bus.out_data}, 32'hFF);
    bus.out_ready = 1'b0;
    snap();
    for (int i = 0; i < 5; i++) begin
      step();
      check_value("t4_in_ready", {31'd0, bus.in_ready}, 32'd0);
      check_value("t4_hold_valid", {31'd0, bus.out_valid}, 32'd1);
      check_value("t4_hold_data", {24'd0, bus.out_data}, 32'hFF);
    end
    check_value("t4_stall_pulses", (adv_cnt - adv_snap) + (rst_cnt - rst_snap), 32'd0);
    bus.out_ready = 1'b1;
    send(8'h00, 1'b0, 1'b0);
    check_value("t4_d1", {24'd0, bus.out_data}, 32'h17);
    send(8'h00, 1'b0, 1'b0);
    check_value("t4_d2", {24'd0, bus.out_data}, 32'hC0);
    idle();
    step();
    check_value("t4_drain", {31'd0, bus.out_valid}, 32'd0);

    // scr_disable suppresses only the XOR, sampled per symbol
    snap();
    scr_disable = 1'b1;
    send(8'hBC, 1'b1, 1'b0);
    send(8'h00, 1'b0, 1'b0);
    check_value("t5_d0", {24'd0, bus.out_data}, 32'h00);
    send(8'h00, 1'b0, 1'b0);
    check_value("t5_d1", {24'd0, bus.out_data}, 32'h00);
    check_value("t5_adv", adv_cnt - adv_snap, 32'd2);
    scr_disable = 1'b0;
    send(8'h00, 1'b0, 1'b0);
    check_value("t5_d2", {24'd0, bus.out_data}, 32'hC0);

    // COM without ts_start aborts a set in progress
    send(8'hBC, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) send(8'h55, 1'b0, 1'b0);
    snap();
    send(8'hBC, 1'b1, 1'b0);
    check_value("t6_abort_ts", {31'd0, ts_active}, 32'd0);
    check_value("t6_abort_rst", rst_cnt - rst_snap, 32'd1);
    send(8'h00, 1'b0, 1'b0);
    check_value("t6_abort_d", {24'd0, bus.out_data}, 32'hFF);

    // Reset in the middle of a TS set
    send(8'hBC, 1'b1, 1'b1);
    for (int i = 1; i < 7; i++) send(8'h4A, 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    check_value("t7_rst_valid", {31'd0, bus.out_valid}, 32'd0);
    check_value("t7_rst_ts", {31'd0, ts_active}, 32'd0);
    idle();
    step();
    reset = 1'b0;
    step();
    send(8'hBC, 1'b1, 1'b0);
    send(8'h00, 1'b0, 1'b0);
    check_value("t7_post_d", {24'd0, bus.out_data}, 32'hFF);
    idle();
    step();

    check_value("never_both_pulses", both_cnt, 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
